// File: rtl/jk_mod_counter_if.sv
// rtl/jk_mod_counter_if.sv - control/status bundle for the JK modulo-N counter
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic             tc;
  logic             done;

  modport master (
    output en, up, load, din, oneshot,
    input  count, count_bar, tc, done
  );

  modport slave (
    input  en, up, load, din, oneshot,
    output count, count_bar, tc, done
  );
endinterface

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - loadable modulo-N up/down counter built from JK stages
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  jk_mod_counter_if.slave        bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] loaded;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;
  logic             at_term;

  // Terminal value, one modulo step in the sampled direction, and the clamped load value
  always_comb begin
    term    = bus.up ? MAX_C : '0;
    at_term = (count_q == term);
    if (bus.up) begin
      stepped = (count_q == MAX_C) ? '0 : count_q + WIDTH'(1);
    end else begin
      stepped = (count_q == '0) ? MAX_C : count_q - WIDTH'(1);
    end
    loaded = (bus.din > MAX_C) ? MAX_C : bus.din;
  end

  // Next count and next state; load outranks every state action
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (bus.load) begin
      count_d = loaded;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.en) begin
            count_d = stepped;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.en) begin
            if (at_term && bus.oneshot) begin
              state_d = DONE;
            end else begin
              count_d = stepped;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // J/K controls per stage: set when the bit must rise, clear when it must fall
  always_comb begin
    j_w = count_d & ~count_q;
    k_w = ~count_d & count_q;
  end

  // JK stages and state register; q+ = J&~q | ~K&q
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      state_q <= IDLE;
    end else begin
      count_q <= (j_w & ~count_q) | (~k_w & count_q);
      state_q <= state_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.count_bar = ~count_q;
  assign bus.done      = (state_q == DONE);
  assign bus.tc        = bus.en & at_term & (state_q != DONE) & ~bus.load;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jk_mod_counter_if #(.WIDTH(W)) bus ();

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int m_cnt  = 0;
  int m_st   = 0;   // 0 idle, 1 running, 2 finished

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int d, input bit o);
    rst_n       = r;
    bus.en      = e;
    bus.up      = u;
    bus.load    = l;
    bus.din     = W'(d);
    bus.oneshot = o;
  endtask

  function automatic int target();
    return bus.up ? M - 1 : 0;
  endfunction

  function automatic int exp_tc();
    return (bus.en && m_cnt == target() && m_st != 2 && !bus.load) ? 1 : 0;
  endfunction

  function automatic int next_val(input int c);
    return bus.up ? (c + 1) % M : (c + M - 1) % M;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0;
      m_st  = 0;
    end else if (bus.load) begin
      m_cnt = (int'(bus.din) > M - 1) ? M - 1 : int'(bus.din);
      m_st  = 0;
    end else if (m_st == 0) begin
      if (bus.en) begin
        m_cnt = next_val(m_cnt);
        m_st  = 1;
      end
    end else if (m_st == 1) begin
      if (bus.en) begin
        if (m_cnt == target() && bus.oneshot) m_st = 2;
        else m_cnt = next_val(m_cnt);
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    check({tag, ".tc"}, 32'(bus.tc), 32'(exp_tc()));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
    check({tag, ".count_bar"}, 32'(bus.count_bar), 32'((~m_cnt) & ((1 << W) - 1)));
    check({tag, ".done"}, 32'(bus.done), 32'(m_st == 2));
  endtask

  initial begin
    drive(0, 1, 1, 1, 7, 0);
    cyc("reset0");
    cyc("reset1");
    check("reset.count_lit", 32'(bus.count), 32'd0);
    check("reset.bar_lit", 32'(bus.count_bar), 32'hF);

    drive(1, 0, 1, 0, 0, 0);
    cyc("release");

    drive(1, 1, 1, 0, 0, 0);
    repeat (11) cyc("upwrap");
    check("upwrap.final_lit", 32'(bus.count), 32'd1);

    drive(1, 0, 1, 1, 2, 0);
    cyc("down.load");
    drive(1, 1, 0, 0, 0, 0);
    repeat (4) cyc("downwrap");
    check("downwrap.final_lit", 32'(bus.count), 32'd8);

    drive(1, 0, 1, 1, 7, 1);
    cyc("os.load7");
    drive(1, 1, 1, 0, 0, 1);
    repeat (5) cyc("oneshot");
    check("oneshot.done_lit", 32'(bus.done), 32'd1);
    check("oneshot.count_lit", 32'(bus.count), 32'd9);
    drive(1, 1, 1, 1, 3, 1);
    cyc("os.reload");
    check("os.reload_lit", 32'(bus.count), 32'd3);

    drive(1, 1, 1, 1, 14, 0);
    cyc("clamp");
    check("clamp.count_lit", 32'(bus.count), 32'd9);
    drive(1, 0, 1, 0, 0, 0);
    repeat (3) cyc("clamp.hold");

    drive(1, 0, 1, 1, 0, 0);
    cyc("flip.load0");
    drive(1, 1, 1, 0, 0, 0);
    repeat (5) cyc("flip.climb");
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, (i % 2) == 1, 0, 0, 0);
      cyc("flip.toggle");
    end
    check("flip.final_lit", 32'(bus.count), 32'd5);
    drive(0, 1, 0, 0, 0, 0);
    cyc("midreset");
    check("midreset.count_lit", 32'(bus.count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(39, 0) != 0,
            $urandom_range(3, 0) != 0,
            1'($urandom),
            $urandom_range(7, 0) == 0,
            int'($urandom_range((1 << W) - 1, 0)),
            1'($urandom));
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state bits are JK flip-flop stages, each driven by derived J/K controls. It is the consumer stage for the single JK flip-flop: it chains WIDTH such stages into a loadable counter with terminal-count and one-shot control. Downstream sequential blocks (dividers, sequencers, timers) use it as a tick and count source.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low; when rst=0 at a rising clk edge the block resets.
- en  input  1  count enable.
- up  input  1  direction, sampled every edge: 1 = up, 0 = down.
- load  input  1  synchronous parallel load; takes priority over en.
- din  input  WIDTH  load value.
- oneshot  input  1  1 = stop at the terminal value instead of wrapping.
- count  output  WIDTH  current count (JK q bits).
- count_bar  output  WIDTH  bitwise complement of count (JK q_bar bits), always ~count.
- tc  output  1  terminal-count indicator.
- done  output  1  high while in the DONE state.

## Operation
- Each bit i is a JK stage: j_i = next_i & ~q_i, k_i = ~next_i & q_i. The result equals a plain register load of next. The JK form is required so that each stage maps onto the existing flip-flop.
- The terminal value T is MODULUS-1 when up=1 and 0 when up=0.
- Load rule: if din > MODULUS-1, the loaded value is clamped to MODULUS-1.
- Priority per edge: rst=0, then load, then the state-machine action.
- State machine (states IDLE, RUN, DONE):
  - IDLE, entered by reset.
    - load=1: count=din (clamped), stay IDLE.
    - en=1: count advances one step, go to RUN.
    - Otherwise hold.
  - RUN:
    - load=1: count=din, go to IDLE.
    - en=0: hold.
    - en=1 and count≠T: count ±1.
    - en=1, count=T, oneshot=0: wrap. Up goes MODULUS-1→0; down goes 0→MODULUS-1. Stay RUN.
    - en=1, count=T, oneshot=1: count stays T, go to DONE.
  - DONE: count held and en ignored.
    - load=1: count=din, go to IDLE.
    - Otherwise only reset exits DONE.
- tc = en & (count==T) & (state≠DONE) & ~load. It is combinational from registered state and current inputs, and is high in the cycle before the wrap or stop edge.
- done = (state==DONE), registered.
- Arithmetic is modulo MODULUS. When MODULUS = 2^WIDTH, the wrap is natural binary overflow.

## Timing
- Reset values: count=0, count_bar=all ones, tc=0, done=0, state=IDLE.
- Reset applies at the first rising edge with rst=0 and overrides load and en in that cycle.
- Latency: count, count_bar and done change one clk edge after the qualifying inputs. tc has zero latency from en and up.
- A direction change takes effect on the edge where it is sampled. No extra step is taken, and T is re-evaluated immediately.
- load and en both high: load wins; no count step occurs and tc=0.
- Asserting rst mid-count discards the count, the state and any pending DONE.
- count_bar must never differ from ~count in any cycle, including the reset cycle.

## Test plan
- Reset: hold rst=0 for 2 edges with en=1, load=1, din=7 -> count=0, count_bar=4'hF, tc=0, done=0. Release -> counting starts on the next en edge.
- Up wrap, defaults, oneshot=0, en=1, up=1 for 11 edges -> count goes 1..9, then 0, then 1. tc=1 only in the cycle where count=9. State stays RUN.
- Down wrap: load din=2, then up=0, en=1 for 4 edges -> count goes 1, 0, 9, 8. tc=1 while count=0.
- One-shot: load 7, oneshot=1, up=1, en=1 for 5 edges -> count 8, 9, 9, 9, 9. done=1 from the third edge onward. Then load din=3 -> count=3, done=0, state IDLE.
- Clamp and priority: load=1 with din=4'hE and en=1 -> count=9, no step. Then en=0 for 3 edges -> count holds at 9 and tc=0.
- Direction flip and mid-run reset: count up to 5, then toggle up every edge -> count goes 4, 5, 4, 5. Assert rst=0 mid-sequence -> next edge gives count=0, state IDLE.
